// File: rtl/pack_pkg.sv
// Shared constants, beat-counter sizing and FSM encoding for the packet arbiter.
package pack_pkg;

    localparam int SIZE_BIT_PACK     = 1976;
    localparam int SIZE_INPUT_BIT    = 8;
    localparam int LENGTHE_INPUT_BIT = SIZE_BIT_PACK / SIZE_INPUT_BIT;

    function automatic int beat_cnt_w(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

    localparam int BEAT_CNT_W = beat_cnt_w(LENGTHE_INPUT_BIT);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin selector: a lone requester wins, a tie goes to the one not served last.
module rr_pick2 (
    input  logic req0,
    input  logic req1,
    input  logic last_served,
    output logic pick
);

    assign pick = (req0 && req1) ? ~last_served : req1;

endmodule

// File: rtl/pack_arbiter.sv
// Shares one Pack instance between two byte-stream requesters, one whole packet per grant.
module pack_arbiter
    import pack_pkg::*;
#(
    parameter int SIZE_BIT_PACK     = pack_pkg::SIZE_BIT_PACK,
    parameter int SIZE_INPUT_BIT    = pack_pkg::SIZE_INPUT_BIT,
    parameter int LENGTHE_INPUT_BIT = SIZE_BIT_PACK / SIZE_INPUT_BIT
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic [SIZE_INPUT_BIT-1:0] i_data0,
    input  logic [SIZE_INPUT_BIT-1:0] i_data1,
    input  logic                      i_valid0,
    input  logic                      i_valid1,
    output logic                      o_ready0,
    output logic                      o_ready1,
    output logic [SIZE_INPUT_BIT-1:0] o_data,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic [1:0]                o_grant,
    output logic                      o_pack_done
);

    localparam int               CNT_W    = beat_cnt_w(LENGTHE_INPUT_BIT);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LENGTHE_INPUT_BIT - 1);

    arb_state_e       state, state_n;
    logic             owner;
    logic             last_served;
    logic [CNT_W-1:0] cnt;
    logic             pick;
    logic             beat;
    logic             last_beat;

    rr_pick2 u_pick (
        .req0        (i_valid0),
        .req1        (i_valid1),
        .last_served (last_served),
        .pick        (pick)
    );

    assign last_beat = (cnt == LAST_CNT);

    // NOTE: every output and next-state signal gets a default first so no latch is inferred.
    always_comb begin
        state_n  = state;
        o_grant  = 2'b00;
        o_valid  = 1'b0;
        o_data   = '0;
        o_ready0 = 1'b0;
        o_ready1 = 1'b0;
        beat     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_valid0 || i_valid1) state_n = ST_GRANT;
            end
            ST_GRANT: begin
                o_grant  = owner ? 2'b10 : 2'b01;
                o_valid  = owner ? i_valid1 : i_valid0;
                o_data   = owner ? i_data1 : i_data0;
                o_ready0 = ~owner & i_ready;
                o_ready1 = owner & i_ready;
                beat     = o_valid & i_ready;
                if (beat && last_beat) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    // Pointer resets to requester 1 so requester 0 takes the first tie.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state       <= ST_IDLE;
            owner       <= 1'b0;
            last_served <= 1'b1;
            cnt         <= '0;
            o_pack_done <= 1'b0;
        end else begin
            state       <= state_n;
            o_pack_done <= beat && last_beat;
            if (state == ST_IDLE && (i_valid0 || i_valid1)) owner <= pick;
            if (beat) begin
                cnt <= last_beat ? '0 : cnt + CNT_W'(1);
                if (last_beat) last_served <= owner;
            end
        end
    end

endmodule

// File: tb/tb_pack_arbiter.sv
// Self-checking bench for pack_arbiter: vector tables, directed corner sequences, random traffic vs a packet-level model.
module tb_pack_arbiter;

    localparam int W     = 8;
    localparam int BEATS = 1976 / 8;

    logic         i_clk = 1'b0;
    logic         i_reset;
    logic [W-1:0] i_data0, i_data1, o_data;
    logic         i_valid0, i_valid1, i_ready;
    logic         o_ready0, o_ready1, o_valid, o_pack_done;
    logic [1:0]   o_grant;

    always #5 i_clk = ~i_clk;

    pack_arbiter dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_data0     (i_data0),
        .i_data1     (i_data1),
        .i_valid0    (i_valid0),
        .i_valid1    (i_valid1),
        .o_ready0    (o_ready0),
        .o_ready1    (o_ready1),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_grant     (o_grant),
        .o_pack_done (o_pack_done)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: who owns the Pack, how many bytes of the current packet have been accepted.
    bit m_busy;
    int m_owner;
    int m_beats;
    int m_last;
    bit m_done;

    task automatic model_reset();
        m_busy  = 1'b0;
        m_owner = 0;
        m_beats = 0;
        m_last  = 1;
        m_done  = 1'b0;
    endtask

    task automatic model_update();
        bit fin = 1'b0;
        if (!m_busy) begin
            if (i_valid0 || i_valid1) begin
                m_busy  = 1'b1;
                m_owner = (i_valid0 && i_valid1) ? 1 - m_last : (i_valid1 ? 1 : 0);
            end
        end else if ((m_owner == 1 ? i_valid1 : i_valid0) && i_ready) begin
            m_beats++;
            if (m_beats == BEATS) begin
                fin     = 1'b1;
                m_beats = 0;
                m_last  = m_owner;
                m_busy  = 1'b0;
            end
        end
        m_done = fin;
    endtask

    task automatic model_check();
        logic [1:0]   eg;
        logic         ev;
        logic [W-1:0] ed;
        eg = m_busy ? (m_owner == 1 ? 2'b10 : 2'b01) : 2'b00;
        ev = m_busy && (m_owner == 1 ? i_valid1 : i_valid0);
        ed = !m_busy ? '0 : (m_owner == 1 ? i_data1 : i_data0);
        check("grant",  o_grant, eg);
        check("valid",  o_valid, ev);
        check("data",   o_data, ed);
        check("ready0", o_ready0, m_busy && m_owner == 0 && i_ready);
        check("ready1", o_ready1, m_busy && m_owner == 1 && i_ready);
        check("done",   o_pack_done, m_done);
    endtask

    // Observations gathered at every negedge for sequence-level checks.
    int         obs_beats, obs_done, obs_ready0, beats_at_done;
    logic [1:0] prev_grant;
    logic [1:0] starts[$];

    task automatic clear_obs();
        obs_beats     = 0;
        obs_done      = 0;
        obs_ready0    = 0;
        beats_at_done = -1;
        starts.delete();
    endtask

    task automatic drive(input logic v0, input logic v1, input logic [W-1:0] d0,
                         input logic [W-1:0] d1, input logic rdy);
        i_valid0 = v0;
        i_valid1 = v1;
        i_data0  = d0;
        i_data1  = d1;
        i_ready  = rdy;
    endtask

    task automatic cycle();
        @(negedge i_clk);
        model_check();
        if (o_pack_done && beats_at_done < 0) beats_at_done = obs_beats;
        if (o_valid && i_ready) obs_beats++;
        if (o_pack_done) obs_done++;
        if (o_ready0) obs_ready0++;
        if (o_grant != 2'b00 && prev_grant == 2'b00) starts.push_back(o_grant);
        prev_grant = o_grant;
        @(posedge i_clk);
        model_update();
        #1;
    endtask

    task automatic do_reset();
        i_reset = 1'b0;
        #1;
        model_reset();
        model_check();
        repeat (2) @(posedge i_clk);
        #1;
        i_reset    = 1'b1;
        prev_grant = 2'b00;
    endtask

    typedef struct {
        logic       v0, v1;
        logic [1:0] e_grant;
    } ivec_t;

    typedef struct {
        logic         v0, v1;
        logic [W-1:0] d0, d1;
        logic         rdy;
        logic         e_valid, e_rdy0, e_rdy1;
        logic [W-1:0] e_data;
    } gvec_t;

    ivec_t itab[4];
    gvec_t gtab[5];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] exp_starts[3];
        logic [W-1:0] hold_d;
        int b0, r0;

        itab[0] = '{1'b0, 1'b0, 2'b00};
        itab[1] = '{1'b1, 1'b0, 2'b01};
        itab[2] = '{1'b0, 1'b1, 2'b10};
        itab[3] = '{1'b1, 1'b1, 2'b01};

        gtab[0] = '{1'b1, 1'b0, 8'h81, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h81};
        gtab[1] = '{1'b0, 1'b1, 8'h11, 8'h22, 1'b1, 1'b0, 1'b1, 1'b0, 8'h11};
        gtab[2] = '{1'b1, 1'b1, 8'h33, 8'h44, 1'b0, 1'b1, 1'b0, 1'b0, 8'h33};
        gtab[3] = '{1'b0, 1'b0, 8'h55, 8'h66, 1'b0, 1'b0, 1'b0, 1'b0, 8'h55};
        gtab[4] = '{1'b1, 1'b1, 8'h77, 8'h88, 1'b1, 1'b1, 1'b1, 1'b0, 8'h77};

        exp_starts[0] = 2'b01;
        exp_starts[1] = 2'b10;
        exp_starts[2] = 2'b01;

        drive(1'b0, 1'b0, '0, '0, 1'b0);
        clear_obs();
        do_reset();

        // Arbitration from reset: idle outputs stay zero, then the owner appears after one edge.
        foreach (itab[k]) begin
            do_reset();
            drive(itab[k].v0, itab[k].v1, 8'hA5, 8'h5A, 1'b1);
            @(negedge i_clk);
            check("idle_grant", o_grant, 2'b00);
            check("idle_valid", o_valid, 1'b0);
            check("idle_data", o_data, 8'h00);
            check("idle_ready", {o_ready1, o_ready0}, 2'b00);
            @(posedge i_clk);
            model_update();
            #1;
            check("arb_grant", o_grant, itab[k].e_grant);
        end

        // Combinational muxing while requester 0 owns the Pack.
        do_reset();
        drive(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
        cycle();
        foreach (gtab[k]) begin
            drive(gtab[k].v0, gtab[k].v1, gtab[k].d0, gtab[k].d1, gtab[k].rdy);
            @(negedge i_clk);
            check("mux_grant", o_grant, 2'b01);
            check("mux_valid", o_valid, gtab[k].e_valid);
            check("mux_ready0", o_ready0, gtab[k].e_rdy0);
            check("mux_ready1", o_ready1, gtab[k].e_rdy1);
            check("mux_data", o_data, gtab[k].e_data);
            @(posedge i_clk);
            model_update();
            #1;
        end

        // Single requester, one full packet of 0x81.
        do_reset();
        clear_obs();
        drive(1'b1, 1'b0, 8'h81, 8'h00, 1'b1);
        cycle();
        check("single_grant", o_grant, 2'b01);
        repeat (BEATS) cycle();
        i_valid0 = 1'b0;
        repeat (3) cycle();
        check("single_beats", obs_beats, BEATS);
        check("single_done", obs_done, 1);
        check("single_idle", o_grant, 2'b00);

        // Both requesting from reset: packets alternate 0, 1, 0.
        do_reset();
        clear_obs();
        drive(1'b1, 1'b1, 8'h0F, 8'hF0, 1'b1);
        repeat (3 * (BEATS + 1) + 2) cycle();
        drive(1'b0, 1'b0, '0, '0, 1'b0);
        repeat (2) cycle();
        check("tie_pkts", starts.size() >= 3, 1'b1);
        for (int i = 0; i < 3; i++)
            check($sformatf("tie_owner%0d", i), (i < starts.size()) ? starts[i] : 2'b00, exp_starts[i]);

        // Owner valid toggling every cycle: the packet still counts exactly BEATS.
        do_reset();
        clear_obs();
        drive(1'b1, 1'b0, 8'h3C, 8'h00, 1'b1);
        for (int c = 0; c < 4 * BEATS && obs_done == 0; c++) begin
            cycle();
            i_valid0 = ~i_valid0;
            i_data0  = W'($urandom);
        end
        i_valid0 = 1'b0;
        repeat (2) cycle();
        check("toggle_done", obs_done, 1);
        check("toggle_beats", obs_beats, BEATS);
        check("toggle_done_at", beats_at_done, BEATS);

        // Pack stalls for 10 cycles mid-packet.
        do_reset();
        clear_obs();
        drive(1'b1, 1'b0, 8'h10, 8'h00, 1'b1);
        repeat (51) cycle();
        hold_d   = 8'hC3;
        i_data0  = hold_d;
        i_ready  = 1'b0;
        b0       = obs_beats;
        r0       = obs_ready0;
        repeat (10) cycle();
        check("stall_beats", obs_beats - b0, 0);
        check("stall_ready0", obs_ready0 - r0, 0);
        check("stall_data", o_data, hold_d);
        i_ready = 1'b1;
        repeat (BEATS - 50) cycle();
        i_valid0 = 1'b0;
        repeat (3) cycle();
        check("stall_total", obs_beats, BEATS);
        check("stall_done", obs_done, 1);

        // Reset at beat 100 discards the partial packet.
        do_reset();
        drive(1'b1, 1'b0, 8'h64, 8'h00, 1'b1);
        repeat (101) cycle();
        i_reset = 1'b0;
        #1;
        check("rst_grant", o_grant, 2'b00);
        check("rst_valid", o_valid, 1'b0);
        check("rst_data", o_data, 8'h00);
        check("rst_ready", {o_ready1, o_ready0}, 2'b00);
        check("rst_done", o_pack_done, 1'b0);
        do_reset();
        clear_obs();
        cycle();
        repeat (BEATS) cycle();
        i_valid0 = 1'b0;
        repeat (3) cycle();
        check("rst_after_beats", obs_beats, BEATS);
        check("rst_after_done_at", beats_at_done, BEATS);

        // Requester 1 alone and continuous: back-to-back packets with one idle cycle.
        do_reset();
        clear_obs();
        drive(1'b0, 1'b1, 8'h00, 8'h99, 1'b1);
        repeat (2 * (BEATS + 1) + 4) cycle();
        check("r1_ready0", obs_ready0, 0);
        check("r1_done", obs_done, 2);
        check("r1_starts", starts.size(), 3);
        i_valid1 = 1'b0;
        repeat (BEATS + 2) cycle();

        // Random traffic against the model.
        do_reset();
        for (int c = 0; c < 5000; c++) begin
            drive(($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 5),
                  W'($urandom), W'($urandom), ($urandom_range(0, 3) != 0));
            if ($urandom_range(0, 2499) == 0) do_reset();
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
